// File: rtl/keypad_emulator.sv
`default_nettype none
// ============================================================================
// Module : keypad_emulator
// Desc   : Emulates a mechanical key closing a row/column crossing of a
//          scanned 4x4 keypad, with contact chatter on press and release.
// Macro  : KEYPAD_EMULATOR_BOUNCE_EN compiles in the bounce states and LFSR.
// Rev    : 1.0  initial release
// ============================================================================
module keypad_emulator #(
   parameter int unsigned BOUNCE_CYCLES = 4096,
   parameter int unsigned HOLD_CYCLES   = 2_400_000,
   parameter int unsigned GAP_CYCLES    = 480_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] keypad_vert,
   output logic [3:0] keypad_hori,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   output logic       key_ready,
   output logic       busy,
   output logic       press_done
);

   localparam logic [23:0] c_HOLD_LAST = 24'(HOLD_CYCLES - 1);
   localparam logic [23:0] c_GAP_LAST  = 24'(GAP_CYCLES - 1);

   // Durations outside 1..2^24-1 cannot be represented by the counter.
   if (BOUNCE_CYCLES == 0 || BOUNCE_CYCLES > 32'hFF_FFFF ||
       HOLD_CYCLES   == 0 || HOLD_CYCLES   > 32'hFF_FFFF ||
       GAP_CYCLES    == 0 || GAP_CYCLES    > 32'hFF_FFFF) begin : g_param_out_of_range
   end

`ifdef KEYPAD_EMULATOR_BOUNCE_EN
   localparam logic [23:0] c_BOUNCE_LAST = 24'(BOUNCE_CYCLES - 1);
   typedef enum logic [2:0] {
      IDLE           = 3'd0,
      BOUNCE_PRESS   = 3'd1,
      HOLD           = 3'd2,
      BOUNCE_RELEASE = 3'd3,
      GAP            = 3'd4
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      GAP  = 2'd2
   } state_t;
`endif

   state_t      r_state, w_state_nxt;
   logic [23:0] r_cnt, w_cnt_nxt;
   logic [3:0]  r_code;
   logic        r_press_done;
   logic        w_done_nxt;
   logic        w_accept;
   logic        w_contact;
   logic        w_bounce_contact;

`ifdef KEYPAD_EMULATOR_BOUNCE_EN
   logic [15:0] r_lfsr;
   logic        w_lfsr_fb;

   // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting toward bit 0.
   assign w_lfsr_fb        = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
   assign w_bounce_contact = r_lfsr[0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_lfsr <= 16'hACE1;
      end else if (r_state == BOUNCE_PRESS || r_state == BOUNCE_RELEASE) begin
         r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
      end
   end
`else
   assign w_bounce_contact = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + 24'd1;
      w_done_nxt  = 1'b0;
      w_accept    = 1'b0;
      w_contact   = 1'b0;
      case (r_state)
         IDLE: begin
            w_cnt_nxt = '0;
            if (key_valid) begin
               w_accept = 1'b1;
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
               w_state_nxt = BOUNCE_PRESS;
`else
               w_state_nxt = HOLD;
`endif
            end
         end
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
         BOUNCE_PRESS: begin
            w_contact = w_bounce_contact;
            if (r_cnt == c_BOUNCE_LAST) begin
               w_state_nxt = HOLD;
               w_cnt_nxt   = '0;
            end
         end
         BOUNCE_RELEASE: begin
            w_contact = w_bounce_contact;
            if (r_cnt == c_BOUNCE_LAST) begin
               w_state_nxt = GAP;
               w_cnt_nxt   = '0;
            end
         end
`endif
         HOLD: begin
            w_contact = 1'b1;
            if (r_cnt == c_HOLD_LAST) begin
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
               w_state_nxt = BOUNCE_RELEASE;
`else
               w_state_nxt = GAP;
`endif
               w_cnt_nxt = '0;
            end
         end
         GAP: begin
            if (r_cnt == c_GAP_LAST) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
               w_done_nxt  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_code       <= '0;
         r_press_done <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_press_done <= w_done_nxt;
         if (w_accept) begin
            r_code <= key_code;
         end
      end
   end

   // Closed contact acts as a wire from the selected column to the selected row.
   assign keypad_hori = (w_contact && keypad_vert[r_code[1:0]]) ?
                        (4'b0001 << r_code[3:2]) : 4'b0000;
   assign key_ready   = (r_state == IDLE);
   assign busy        = ~key_ready;
   assign press_done  = r_press_done;

endmodule
`default_nettype wire

// File: tb/tb_keypad_emulator.sv
`default_nettype none
// ============================================================================
// Module : tb_keypad_emulator
// Desc   : Scoreboard bench for keypad_emulator; expectations are queued by
//          stimulus and checked by an independent negedge monitor.
// Rev    : 1.0  initial release
// ============================================================================
module tb_keypad_emulator;

   localparam int B = 8;
   localparam int H = 20;
   localparam int G = 5;
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
   localparam int PRE = B;
   localparam int TOT = 42;
`else
   localparam int PRE = 0;
   localparam int TOT = 26;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] keypad_vert;
   logic [3:0] keypad_hori;
   logic       key_valid;
   logic [3:0] key_code;
   logic       key_ready;
   logic       busy;
   logic       press_done;

   keypad_emulator #(
      .BOUNCE_CYCLES(B),
      .HOLD_CYCLES  (H),
      .GAP_CYCLES   (G)
   ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .keypad_vert(keypad_vert),
      .keypad_hori(keypad_hori),
      .key_valid  (key_valid),
      .key_code   (key_code),
      .key_ready  (key_ready),
      .busy       (busy),
      .press_done (press_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      string      name;
      logic [3:0] hori;
      logic       ready;
      logic       done;
   } exp_t;

   exp_t        sb[$];
   int          cyc = 0;
   int          n_vec = 0;
   int          n_err = 0;
   int          n_done_seen = 0;
   int          n_done_exp = 0;
   logic [15:0] lfsr_m = 16'hACE1;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: check every queued expectation whose cycle has arrived.
   always @(negedge clk) begin
      if (reset) begin
         if (press_done) n_done_seen++;
         for (int i = 0; i < sb.size(); ) begin
            if (sb[i].cyc <= cyc) begin
               n_vec++;
               if (sb[i].cyc != cyc || keypad_hori !== sb[i].hori || key_ready !== sb[i].ready ||
                   busy !== !sb[i].ready || press_done !== sb[i].done) begin
                  n_err++;
                  $display("FAIL %s @cyc %0d (due %0d): hori=%b ready=%b busy=%b done=%b, expected hori=%b ready=%b busy=%b done=%b",
                           sb[i].name, cyc, sb[i].cyc, keypad_hori, key_ready, busy, press_done,
                           sb[i].hori, sb[i].ready, !sb[i].ready, sb[i].done);
               end
               sb.delete(i);
            end else begin
               i++;
            end
         end
      end
   end

   function automatic logic [15:0] lfsr_step(logic [15:0] s);
      return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
   endfunction

   function automatic logic [3:0] hori_of(logic contact, logic [3:0] code, logic [3:0] vert);
      return (contact && vert[code[1:0]]) ? (4'b0001 << code[3:2]) : 4'b0000;
   endfunction

   task automatic push(int c, string nm, logic [3:0] h, logic rdy, logic dn);
      exp_t e;
      e.cyc = c; e.name = nm; e.hori = h; e.ready = rdy; e.done = dn;
      sb.push_back(e);
   endtask

   task automatic chk(string nm, int act, int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic at_cyc(int c);
      while (cyc < c) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Queue a whole sequence whose request is seen at the edge after cycle k.
   task automatic push_seq(int k, logic [3:0] code, logic [3:0] vert, bit hold_chk);
      for (int i = 0; i < PRE; i++) begin
         push(k + 1 + i, "bounce_press", hori_of(lfsr_m[0], code, vert), 1'b0, 1'b0);
         lfsr_m = lfsr_step(lfsr_m);
      end
      if (hold_chk)
         for (int i = 0; i < H; i++)
            push(k + PRE + 1 + i, "hold", hori_of(1'b1, code, vert), 1'b0, 1'b0);
      for (int i = 0; i < PRE; i++) begin
         push(k + PRE + H + 1 + i, "bounce_release", hori_of(lfsr_m[0], code, vert), 1'b0, 1'b0);
         lfsr_m = lfsr_step(lfsr_m);
      end
      for (int i = 0; i < G; i++)
         push(k + 2 * PRE + H + 1 + i, "gap", 4'b0000, 1'b0, 1'b0);
      push(k + TOT, "press_done", 4'b0000, 1'b1, 1'b1);
      n_done_exp++;
   endtask

   logic [3:0] walk[6]     = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1111, 4'b1101};
   logic [3:0] walk_exp[6] = '{4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000};

   initial begin
      int k;
      reset       = 1'b0;
      key_valid   = 1'b0;
      key_code    = 4'h0;
      keypad_vert = 4'b0000;
      #3;
      chk("reset_state", {keypad_hori, key_ready, busy, press_done}, 7'b0000_100);
      at_cyc(3);
      reset = 1'b1;

      // Basic press: code 6 -> row 1, col 2.
      k = cyc;
      key_code = 4'h6; keypad_vert = 4'b0100; key_valid = 1'b1;
      push(k + 1, "accept_busy", (PRE > 0) ? hori_of(lfsr_m[0], 4'h6, 4'b0100) : 4'b0010, 1'b0, 1'b0);
      sb.delete(sb.size() - 1);
      push_seq(k, 4'h6, 4'b0100, 1'b1);
      at_cyc(k + 1);
      key_valid = 1'b0;
      push(k + TOT + 1, "done_one_cycle", 4'b0000, 1'b1, 1'b0);
      at_cyc(k + TOT + 2);

      // Column walk during HOLD: row 2, col 1, including non-one-hot drives.
      k = cyc;
      key_code = 4'h9; keypad_vert = 4'b0010; key_valid = 1'b1;
      push_seq(k, 4'h9, 4'b0010, 1'b0);
      at_cyc(k + 1);
      key_valid = 1'b0;
      for (int j = 0; j < 6; j++) begin
         at_cyc(k + PRE + 1 + j);
         keypad_vert = walk[j];
         push(cyc, "vert_walk", walk_exp[j], 1'b0, 1'b0);
      end
      at_cyc(k + PRE + 7);
      keypad_vert = 4'b0010;
      at_cyc(k + TOT + 2);

      // Key 0 on column 0: bounce follows the LFSR bit 0.
      k = cyc;
      key_code = 4'h0; keypad_vert = 4'b0001; key_valid = 1'b1;
      push_seq(k, 4'h0, 4'b0001, 1'b1);
      at_cyc(k + 1);
      key_valid = 1'b0;
      at_cyc(k + TOT + 2);

      // Request held across a sequence with code changed mid-way.
      k = cyc;
      key_code = 4'hF; keypad_vert = 4'b1000; key_valid = 1'b1;
      push_seq(k, 4'hF, 4'b1000, 1'b1);
      at_cyc(k + 10);
      key_code = 4'h3;
      push_seq(k + TOT, 4'h3, 4'b1000, 1'b1);
      at_cyc(k + TOT + 1);
      key_valid = 1'b0;
      at_cyc(k + 2 * TOT + 2);

      // Reset during HOLD aborts the sequence.
      k = cyc;
      key_code = 4'h6; keypad_vert = 4'b0100; key_valid = 1'b1;
      push(k + PRE + 3, "pre_abort_hold", 4'b0010, 1'b0, 1'b0);
      at_cyc(k + 1);
      key_valid = 1'b0;
      at_cyc(k + PRE + 5);
      reset = 1'b0;
      #1;
      chk("reset_mid_hold", {keypad_hori, key_ready, busy, press_done}, 7'b0000_100);
      lfsr_m = 16'hACE1;
      at_cyc(k + PRE + 8);
      reset = 1'b1;
      at_cyc(k + TOT + 3);

      k = cyc;
      key_valid = 1'b1;
      push_seq(k, 4'h6, 4'b0100, 1'b1);
      at_cyc(k + 1);
      key_valid = 1'b0;
      at_cyc(k + TOT + 3);

      chk("done_pulse_count", n_done_seen, n_done_exp);
      chk("scoreboard_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/keypad_emulator.md
KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Interface
REQ-001 Parameter BOUNCE_CYCLES, default 4096: clock cycles of contact chatter on press and on release.
REQ-002 Parameter HOLD_CYCLES, default 2_400_000: clock cycles the contact is held solidly closed.
REQ-003 Parameter GAP_CYCLES, default 480_000: clock cycles the contact stays open after release, before the next request is accepted.
REQ-004 clk  input  1  single system clock; all state is clocked on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 keypad_vert  input  4  column drive from the scanner; active-high; one-hot when the scanner is operating normally.
REQ-007 keypad_hori  output  4  row sense returned to the scanner; active-high.
REQ-008 key_valid  input  1  a press request is present on key_code.
REQ-009 key_code  input  4  key to press; row = key_code[3:2], column = key_code[1:0].
REQ-010 key_ready  output  1  the emulator can accept a request.
REQ-011 busy  output  1  a press sequence is in progress.
REQ-012 press_done  output  1  one-cycle pulse marking the end of a sequence.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, BOUNCE_PRESS, HOLD, BOUNCE_RELEASE and GAP.
REQ-014 key_ready SHALL be 1 only in IDLE; busy SHALL equal ~key_ready.
REQ-015 A request SHALL be accepted at the rising edge where key_valid=1 and key_ready=1; key_code is captured into an internal register at that edge.
REQ-016 key_valid SHALL be ignored while key_ready=0; a request held high across a sequence is accepted once that sequence returns to IDLE.
REQ-017 After acceptance, the FSM SHALL move through the states in this order, each lasting exactly its parameter count of cycles:
- BOUNCE_PRESS: BOUNCE_CYCLES
- HOLD: HOLD_CYCLES
- BOUNCE_RELEASE: BOUNCE_CYCLES
- GAP: GAP_CYCLES
It then returns to IDLE.
REQ-018 press_done SHALL be 1 for exactly the single cycle after the GAP state ends, i.e. the first cycle in IDLE.
REQ-019 The internal contact state SHALL be:
- 1 in HOLD;
- LFSR bit 0 in BOUNCE_PRESS and BOUNCE_RELEASE;
- 0 in IDLE and GAP.
REQ-020 The LFSR SHALL be 16 bits with taps x^16+x^14+x^13+x^11+1, seeded 16'hACE1, advancing one step every cycle the FSM is in a bounce state.
REQ-021 When the contact is closed and keypad_vert[col] is 1, keypad_hori SHALL equal one-hot(row); otherwise keypad_hori SHALL be 4'b0000.
REQ-022 The path from keypad_vert to keypad_hori SHALL be combinational (zero cycles), modelling a wire through a closed switch.
REQ-023 If keypad_vert is not one-hot, only bit col SHALL be examined; all other column bits SHALL be ignored.
REQ-024 Each state's duration counter SHALL be 24 bits, and every parameter SHALL be in the range 1 to 2^24-1.
REQ-025 Simultaneous end of GAP and key_valid=1: the request SHALL be accepted on the first IDLE cycle, not on the GAP cycle.

Reset
REQ-026 While reset=0, the following SHALL hold immediately (asynchronously):
- FSM = IDLE, counter = 0, LFSR = 16'hACE1;
- contact open, keypad_hori = 0;
- key_ready = 1, busy = 0, press_done = 0.
REQ-027 Reset asserted mid-sequence SHALL abort the sequence with no press_done pulse; the captured key_code is discarded.

Configuration
REQ-028 Macro KEYPAD_EMULATOR_BOUNCE_EN, when defined, SHALL compile in the bounce states and the LFSR as specified above.
REQ-029 When KEYPAD_EMULATOR_BOUNCE_EN is undefined, the block SHALL behave as follows:
- BOUNCE_PRESS and BOUNCE_RELEASE and the LFSR SHALL be omitted;
- the sequence SHALL be IDLE -> HOLD -> GAP -> IDLE;
- press_done timing SHALL shorten by 2*BOUNCE_CYCLES cycles.

Verification (bench: BOUNCE_CYCLES=8, HOLD_CYCLES=20, GAP_CYCLES=5)
REQ-030 Reset is released, then key_code=4'h6 is requested with keypad_vert=4'b0100 held constant -> keypad_hori=4'b0010 solid for 20 cycles in HOLD; press_done pulses 42 cycles after acceptance (bounce enabled), or 26 cycles with the macro undefined.
REQ-031 HOLD is active with row=2, col=1, and keypad_vert walks 0001,0010,0100,1000 -> keypad_hori = 0000,0100,0000,0000, each changing in the same cycle as keypad_vert.
REQ-032 Bounce enabled, key_code=4'h0, keypad_vert=4'b0001 -> during the 8 BOUNCE_PRESS cycles, keypad_hori[0] equals LFSR bit 0 starting from seed 16'hACE1.
REQ-033 key_valid is held high with code 4'hF then switched to code 4'h3 mid-sequence -> exactly one 4'hF sequence runs; the 4'h3 request is accepted on the first IDLE cycle.
REQ-034 reset is pulled low during HOLD -> keypad_hori=0 and key_ready=1 immediately; no press_done pulse; the next request restarts the sequence with the LFSR at its seed.
